// File: rtl/control_fsm_mc.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback with a
// ready-handshaked memory port. Define CONTROL_FSM_INSTRET_EN to build the retired-instruction counter.
`timescale 1ns/1ps

package control_fsm_mc_pkg;
    typedef logic [6:0] opcode_t;

    localparam opcode_t OpRType      = 7'b0110011;
    localparam opcode_t OpITypeLogic = 7'b0010011;
    localparam opcode_t OpITypeLoad  = 7'b0000011;
    localparam opcode_t OpITypeJalr  = 7'b1100111;
    localparam opcode_t OpSType      = 7'b0100011;
    localparam opcode_t OpBType      = 7'b1100011;
    localparam opcode_t OpJType      = 7'b1101111;
    localparam opcode_t OpUTypeLui   = 7'b0110111;
    localparam opcode_t OpUTypeAuipc = 7'b0010111;

    typedef enum logic {AdrPc = 1'b0, AdrResult = 1'b1} adr_src_t;
    typedef enum logic [1:0] {PcIncrement = 2'd0, PcJump = 2'd1, PcAluResult = 2'd2} pc_src_t;
    typedef enum logic [1:0] {
        SrcAOldPc = 2'd0, SrcARd1 = 2'd1, SrcAZero = 2'd2, SrcAPc = 2'd3
    } alu_src_a_t;
    typedef enum logic [1:0] {SrcBImmExt = 2'd0, SrcBRd2 = 2'd1, SrcBFour = 2'd2} alu_src_b_t;
    typedef enum logic [1:0] {ResAluOut = 2'd0, ResData = 2'd1, ResAluResult = 2'd2} result_src_t;
endpackage

module control_fsm_mc
    import control_fsm_mc_pkg::*;
#(
    parameter int unsigned INSTRET_W   = 32,
    parameter bit          TRAP_STICKY = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  opcode_t              opcode,
    input  logic [2:0]           funct3,
    input  logic                 zero_flag,
    input  logic                 lt_flag,
    input  logic                 ltu_flag,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output adr_src_t             adr_src,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic                 pc_update,
    output pc_src_t              pc_src,
    output alu_src_a_t           alu_src_a,
    output alu_src_b_t           alu_src_b,
    output logic [2:0]           alu_op,
    output result_src_t          result_src,
    output logic                 branch,
    output logic [4:0]           fsm_state,
    output logic                 illegal_instr,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [4:0] {
        StFetch      = 5'd0,
        StDecode     = 5'd1,
        StExecuteR   = 5'd2,
        StUncondJump = 5'd3,
        StExecuteI   = 5'd4,
        StMemAdr     = 5'd5,
        StAluWb      = 5'd6,
        StMemWrite   = 5'd7,
        StMemRead    = 5'd8,
        StMemWb      = 5'd9,
        StBranch     = 5'd10,
        StLui        = 5'd11,
        StAuipc      = 5'd12,
        StJalrCalc   = 5'd13,
        StJalrStep2  = 5'd14,
        StTrap       = 5'd15
    } state_e;

    state_e state_q;
    logic   br_taken;
    logic   br_illegal;

    // funct3 010/011 are not branch encodings and divert to TRAP.
    always_comb begin
        br_taken   = 1'b0;
        br_illegal = 1'b0;
        unique case (funct3)
            3'b000:  br_taken = zero_flag;
            3'b001:  br_taken = !zero_flag;
            3'b100:  br_taken = lt_flag;
            3'b101:  br_taken = !lt_flag;
            3'b110:  br_taken = ltu_flag;
            3'b111:  br_taken = !ltu_flag;
            default: br_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            unique case (state_q)
                StFetch:      if (mem_ready) state_q <= StDecode;
                StDecode: begin
                    case (opcode)
                        OpJType:      state_q <= StUncondJump;
                        OpRType:      state_q <= StExecuteR;
                        OpITypeLogic: state_q <= StExecuteI;
                        OpITypeLoad:  state_q <= StMemAdr;
                        OpSType:      state_q <= StMemAdr;
                        OpBType:      state_q <= StBranch;
                        OpUTypeAuipc: state_q <= StAuipc;
                        OpUTypeLui:   state_q <= StLui;
                        OpITypeJalr:  state_q <= StJalrCalc;
                        default:      state_q <= StTrap;
                    endcase
                end
                StExecuteR:   state_q <= StAluWb;
                StExecuteI:   state_q <= StAluWb;
                StLui:        state_q <= StAluWb;
                StAuipc:      state_q <= StAluWb;
                StUncondJump: state_q <= StAluWb;
                StJalrCalc:   state_q <= StJalrStep2;
                StJalrStep2:  state_q <= StAluWb;
                StMemAdr:     state_q <= (opcode == OpSType) ? StMemWrite : StMemRead;
                StMemRead:    if (mem_ready) state_q <= StMemWb;
                StMemWb:      state_q <= StFetch;
                StMemWrite:   if (mem_ready) state_q <= StFetch;
                StAluWb:      state_q <= StFetch;
                StBranch:     state_q <= br_illegal ? StTrap : StFetch;
                StTrap:       if (!TRAP_STICKY) state_q <= StFetch;
                default:      state_q <= StTrap;
            endcase
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = AdrPc;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        pc_update     = 1'b0;
        pc_src        = PcIncrement;
        alu_src_a     = SrcAOldPc;
        alu_src_b     = SrcBImmExt;
        alu_op        = 3'b000;
        result_src    = ResAluOut;
        branch        = 1'b0;
        illegal_instr = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                ir_write  = mem_ready;
                pc_update = mem_ready;
            end
            StExecuteR: begin
                alu_src_a = SrcARd1;
                alu_src_b = SrcBRd2;
                alu_op    = 3'b010;
            end
            StExecuteI: begin
                alu_src_a = SrcARd1;
                alu_op    = 3'b011;
            end
            StUncondJump: begin
                alu_src_b = SrcBFour;
                pc_update = 1'b1;
                pc_src    = PcJump;
            end
            StMemAdr:   alu_src_a = SrcARd1;
            StJalrCalc: alu_src_a = SrcARd1;
            StLui:      alu_src_a = SrcAZero;
            StJalrStep2: begin
                alu_src_b = SrcBFour;
                pc_src    = PcAluResult;
                pc_update = 1'b1;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = AdrResult;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = AdrResult;
            end
            StMemWb: begin
                result_src = ResData;
                reg_write  = 1'b1;
            end
            StAluWb: reg_write = 1'b1;
            StBranch: begin
                alu_src_a = SrcARd1;
                alu_src_b = SrcBRd2;
                alu_op    = 3'b001;
                branch    = 1'b1;
                if (br_taken) begin
                    pc_src    = PcJump;
                    pc_update = 1'b1;
                end
            end
            StTrap:  illegal_instr = 1'b1;
            default: ;
        endcase
    end

    assign fsm_state = state_q;

`ifdef CONTROL_FSM_INSTRET_EN
    logic                 retire;
    logic [INSTRET_W-1:0] instret_q;

    assign retire = (state_q == StAluWb) || (state_q == StMemWb) ||
                    (state_q == StBranch && !br_illegal) ||
                    (state_q == StMemWrite && mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_control_fsm_mc.sv
// Self-checking bench for control_fsm_mc: a sticky 32-bit-counter instance and a
// non-sticky 2-bit-counter instance run side by side against per-instruction state traces.
`timescale 1ns/1ps

module tb_control_fsm_mc;
    import control_fsm_mc_pkg::*;

    localparam logic [4:0] SFetch = 5'd0, SDecode = 5'd1, SExecR = 5'd2, SJump = 5'd3;
    localparam logic [4:0] SExecI = 5'd4, SMemAdr = 5'd5, SAluWb = 5'd6, SMemWr = 5'd7;
    localparam logic [4:0] SMemRd = 5'd8, SMemWb = 5'd9, SBranch = 5'd10, SLui = 5'd11;
    localparam logic [4:0] SAuipc = 5'd12, SJalrC = 5'd13, SJalr2 = 5'd14, STrap = 5'd15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    opcode_t opcode = OpRType;
    logic [2:0] funct3 = 3'b000;
    logic zero_flag = 1'b0, lt_flag = 1'b0, ltu_flag = 1'b0, mem_ready = 1'b0;

    logic mem_req0, mem_write0, ir_write0, reg_write0, pc_update0, branch0, illegal0;
    adr_src_t adr_src0; pc_src_t pc_src0; alu_src_a_t src_a0; alu_src_b_t src_b0;
    logic [2:0] alu_op0; result_src_t res0; logic [4:0] st0; logic [31:0] instret0;

    logic mem_req1, mem_write1, ir_write1, reg_write1, pc_update1, branch1, illegal1;
    adr_src_t adr_src1; pc_src_t pc_src1; alu_src_a_t src_a1; alu_src_b_t src_b1;
    logic [2:0] alu_op1; result_src_t res1; logic [4:0] st1; logic [1:0] instret1;

    control_fsm_mc dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero_flag(zero_flag),
        .lt_flag(lt_flag), .ltu_flag(ltu_flag), .mem_ready(mem_ready), .mem_req(mem_req0),
        .mem_write(mem_write0), .adr_src(adr_src0), .ir_write(ir_write0),
        .reg_write(reg_write0), .pc_update(pc_update0), .pc_src(pc_src0),
        .alu_src_a(src_a0), .alu_src_b(src_b0), .alu_op(alu_op0), .result_src(res0),
        .branch(branch0), .fsm_state(st0), .illegal_instr(illegal0), .instret(instret0)
    );

    control_fsm_mc #(.INSTRET_W(2), .TRAP_STICKY(1'b0)) dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero_flag(zero_flag),
        .lt_flag(lt_flag), .ltu_flag(ltu_flag), .mem_ready(mem_ready), .mem_req(mem_req1),
        .mem_write(mem_write1), .adr_src(adr_src1), .ir_write(ir_write1),
        .reg_write(reg_write1), .pc_update(pc_update1), .pc_src(pc_src1),
        .alu_src_a(src_a1), .alu_src_b(src_b1), .alu_op(alu_op1), .result_src(res1),
        .branch(branch1), .fsm_state(st1), .illegal_instr(illegal1), .instret(instret1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] st;
        logic       rdy;
        logic       taken;
    } step_t;

    typedef struct {
        logic [4:0] st0, st1;
        logic       mem_req, mem_write, ir_write, reg_write, pc_update, branch, illegal;
        logic       adr_src;
        logic [1:0] pc_src, src_a, src_b, res;
        logic [2:0] alu_op;
    } obs_t;

    step_t trace[$];
    obs_t  obs[$];
    int    total = 0;
    int    bad = 0;
    int    exp_ret = 0;

    function automatic logic [31:0] want_instret0();
`ifdef CONTROL_FSM_INSTRET_EN
        return 32'(exp_ret);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [1:0] want_instret1();
`ifdef CONTROL_FSM_INSTRET_EN
        return 2'(exp_ret % 4);
`else
        return 2'd0;
`endif
    endfunction

    function automatic logic exp_taken(input logic [2:0] f3, input logic z, input logic lt,
                                       input logic ltu);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input logic [4:0] s, input logic r, input logic t);
        step_t e;
        e.st = s; e.rdy = r; e.taken = t;
        trace.push_back(e);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected state walk of one instruction; non-memory states get a random mem_ready.
    task automatic build_instr(input opcode_t op, input int fw, input int mw, input logic tk);
        trace.delete();
        for (int i = 0; i < fw; i++) push(SFetch, 1'b0, 1'b0);
        push(SFetch, 1'b1, 1'b0);
        push(SDecode, rnd_bit(), 1'b0);
        case (op)
            OpRType:      begin push(SExecR, rnd_bit(), 1'b0); push(SAluWb, rnd_bit(), 1'b0); end
            OpITypeLogic: begin push(SExecI, rnd_bit(), 1'b0); push(SAluWb, rnd_bit(), 1'b0); end
            OpUTypeLui:   begin push(SLui, rnd_bit(), 1'b0); push(SAluWb, rnd_bit(), 1'b0); end
            OpUTypeAuipc: begin push(SAuipc, rnd_bit(), 1'b0); push(SAluWb, rnd_bit(), 1'b0); end
            OpJType:      begin push(SJump, rnd_bit(), 1'b0); push(SAluWb, rnd_bit(), 1'b0); end
            OpITypeJalr: begin
                push(SJalrC, rnd_bit(), 1'b0); push(SJalr2, rnd_bit(), 1'b0);
                push(SAluWb, rnd_bit(), 1'b0);
            end
            OpITypeLoad: begin
                push(SMemAdr, rnd_bit(), 1'b0);
                for (int i = 0; i < mw; i++) push(SMemRd, 1'b0, 1'b0);
                push(SMemRd, 1'b1, 1'b0); push(SMemWb, rnd_bit(), 1'b0);
            end
            OpSType: begin
                push(SMemAdr, rnd_bit(), 1'b0);
                for (int i = 0; i < mw; i++) push(SMemWr, 1'b0, 1'b0);
                push(SMemWr, 1'b1, 1'b0);
            end
            OpBType: push(SBranch, rnd_bit(), tk);
            default: ;
        endcase
    endtask

    // Drives mem_ready per trace step and records outputs mid-cycle; ends just after the last edge.
    task automatic exec_trace();
        obs.delete();
        foreach (trace[i]) begin
            obs_t o;
            @(negedge clk);
            mem_ready = trace[i].rdy;
            #1;
            o.st0 = st0; o.st1 = st1; o.mem_req = mem_req0; o.mem_write = mem_write0;
            o.ir_write = ir_write0; o.reg_write = reg_write0; o.pc_update = pc_update0;
            o.branch = branch0; o.illegal = illegal0; o.adr_src = adr_src0;
            o.pc_src = pc_src0; o.src_a = src_a0; o.src_b = src_b0; o.res = res0;
            o.alu_op = alu_op0;
            obs.push_back(o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_ret = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (st0 !== SFetch) begin bad++; $display("FAIL reset_state got=%0d want=0", st0); end
        total++; if (st1 !== SFetch) begin bad++; $display("FAIL reset_state1 got=%0d want=0", st1); end
        total++; if (mem_req0 !== 1'b1) begin bad++; $display("FAIL reset_mem_req got=%b want=1", mem_req0); end
        total++; if (ir_write0 !== 1'b0) begin bad++; $display("FAIL reset_ir_write got=%b want=0", ir_write0); end
        total++; if (instret0 !== 32'd0) begin bad++; $display("FAIL reset_instret got=%0d want=0", instret0); end
        total++; if (instret1 !== 2'd0) begin bad++; $display("FAIL reset_instret1 got=%0d want=0", instret1); end
        // Abandon a store that is waiting on memory.
        opcode = OpSType;
        @(negedge clk);
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++; if (st0 !== SMemWr) begin bad++; $display("FAIL store_wait_state got=%0d want=7", st0); end
        total++; if (mem_write0 !== 1'b1) begin bad++; $display("FAIL store_wait_wr got=%b want=1", mem_write0); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_ret = 0;
        total++; if (mem_write0 !== 1'b0) begin bad++; $display("FAIL abort_mem_write got=%b want=0", mem_write0); end
        total++; if (st0 !== SFetch) begin bad++; $display("FAIL abort_state got=%0d want=0", st0); end
        total++; if (mem_req0 !== 1'b1) begin bad++; $display("FAIL abort_mem_req got=%b want=1", mem_req0); end
    endtask

    task automatic test_addi();
        logic [4:0] seq [4] = '{5'd0, 5'd1, 5'd4, 5'd6};
        do_reset();
        opcode = OpITypeLogic;
        build_instr(OpITypeLogic, 0, 0, 1'b0);
        exec_trace();
        exp_ret++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs[k].st0 !== seq[k]) begin
                bad++; $display("FAIL addi_seq[%0d] got=%0d want=%0d", k, obs[k].st0, seq[k]);
            end
            total++;
            if (obs[k].reg_write !== (k == 3)) begin
                bad++; $display("FAIL addi_reg_write[%0d] got=%b want=%b", k, obs[k].reg_write, k == 3);
            end
        end
        total++; if (st0 !== SFetch) begin bad++; $display("FAIL addi_end got=%0d want=0", st0); end
        total++;
        if (instret0 !== want_instret0()) begin
            bad++; $display("FAIL addi_instret got=%0d want=%0d", instret0, want_instret0());
        end
    endtask

    task automatic test_fetch_wait();
        opcode = OpRType;
        build_instr(OpRType, 3, 0, 1'b0);
        exec_trace();
        exp_ret++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs[k].st0 !== SFetch || obs[k].mem_req !== 1'b1 || obs[k].adr_src !== AdrPc) begin
                bad++; $display("FAIL fetch_hold[%0d] got=%0d/%b want=0/1", k, obs[k].st0, obs[k].mem_req);
            end
            total++;
            if (obs[k].ir_write !== (k == 3)) begin
                bad++; $display("FAIL fetch_ir_write[%0d] got=%b want=%b", k, obs[k].ir_write, k == 3);
            end
        end
        total++; if (obs[4].st0 !== SDecode) begin bad++; $display("FAIL fetch_next got=%0d want=1", obs[4].st0); end
    endtask

    task automatic test_branch();
        opcode = OpBType;
        funct3 = 3'b101;
        zero_flag = 1'b0; ltu_flag = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            lt_flag = (pass == 0);
            build_instr(OpBType, 0, 0, exp_taken(funct3, zero_flag, lt_flag, ltu_flag));
            exec_trace();
            exp_ret++;
            total++;
            if (obs[2].st0 !== SBranch || obs[2].branch !== 1'b1) begin
                bad++; $display("FAIL bge_state got=%0d/%b want=10/1", obs[2].st0, obs[2].branch);
            end
            total++;
            if (obs[2].pc_update !== (pass == 1)) begin
                bad++; $display("FAIL bge_pc_update lt=%b got=%b want=%b", lt_flag, obs[2].pc_update, pass == 1);
            end
            if (pass == 1) begin
                total++;
                if (obs[2].pc_src !== PcJump) begin
                    bad++; $display("FAIL bge_pc_src got=%0d want=%0d", obs[2].pc_src, PcJump);
                end
            end
        end
        total++;
        if (instret0 !== want_instret0()) begin
            bad++; $display("FAIL branch_instret got=%0d want=%0d", instret0, want_instret0());
        end
        funct3 = 3'b010;
        trace.delete();
        push(SFetch, 1'b1, 1'b0); push(SDecode, 1'b0, 1'b0); push(SBranch, 1'b0, 1'b0);
        exec_trace();
        total++; if (obs[2].pc_update !== 1'b0) begin bad++; $display("FAIL bad_f3_pc_update got=%b want=0", obs[2].pc_update); end
        total++; if (st0 !== STrap || illegal0 !== 1'b1) begin bad++; $display("FAIL bad_f3_trap got=%0d/%b want=15/1", st0, illegal0); end
        total++;
        if (instret0 !== want_instret0()) begin
            bad++; $display("FAIL bad_f3_instret got=%0d want=%0d", instret0, want_instret0());
        end
    endtask

    task automatic test_load_wait();
        logic [4:0] seq [7] = '{5'd0, 5'd1, 5'd5, 5'd8, 5'd8, 5'd8, 5'd9};
        do_reset();
        opcode = OpITypeLoad;
        build_instr(OpITypeLoad, 0, 2, 1'b0);
        exec_trace();
        exp_ret++;
        for (int k = 0; k < 7; k++) begin
            total++;
            if (obs[k].st0 !== seq[k]) begin
                bad++; $display("FAIL load_seq[%0d] got=%0d want=%0d", k, obs[k].st0, seq[k]);
            end
        end
        total++; if (obs[6].res !== ResData) begin bad++; $display("FAIL load_result_src got=%0d want=1", obs[6].res); end
        total++; if (obs[4].adr_src !== AdrResult) begin bad++; $display("FAIL load_adr_src got=%b want=1", obs[4].adr_src); end
        total++; if (st0 !== SFetch) begin bad++; $display("FAIL load_end got=%0d want=0", st0); end
    endtask

    task automatic test_trap();
        logic [4:0] want1;
        do_reset();
        opcode = 7'h7F;
        trace.delete();
        push(SFetch, 1'b1, 1'b0); push(SDecode, 1'b0, 1'b0);
        exec_trace();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            total++;
            if (st0 !== STrap || illegal0 !== 1'b1 || mem_req0 !== 1'b0 || reg_write0 !== 1'b0) begin
                bad++; $display("FAIL trap_hold[%0d] got=%0d/%b want=15/1", c, st0, illegal0);
            end
            want1 = (c == 0) ? STrap : SFetch;
            total++;
            if (st1 !== want1) begin
                bad++; $display("FAIL trap_nonsticky[%0d] got=%0d want=%0d", c, st1, want1);
            end
        end
        total++; if (instret0 !== 32'd0) begin bad++; $display("FAIL trap_instret got=%0d want=0", instret0); end
        do_reset();
        total++; if (st0 !== SFetch || illegal0 !== 1'b0) begin bad++; $display("FAIL trap_reset got=%0d want=0", st0); end
    endtask

    task automatic test_instret_wrap();
        opcode_t alu_ops [5] = '{OpRType, OpITypeLogic, OpUTypeLui, OpUTypeAuipc, OpJType};
        logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [1:0] want;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            opcode = alu_ops[$urandom_range(0, 4)];
            build_instr(opcode, 0, 0, 1'b0);
            exec_trace();
            exp_ret++;
`ifdef CONTROL_FSM_INSTRET_EN
            want = seq[k];
`else
            want = 2'd0;
`endif
            total++;
            if (instret1 !== want) begin
                bad++; $display("FAIL instret_wrap[%0d] got=%0d want=%0d", k, instret1, want);
            end
        end
    endtask

    task automatic test_random();
        opcode_t ops [9] = '{OpRType, OpITypeLogic, OpUTypeLui, OpUTypeAuipc, OpJType,
                             OpITypeJalr, OpITypeLoad, OpSType, OpBType};
        logic [2:0] f3s [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [4:0] s;
        logic r, t;
        logic [1:0] w_pc_src, w_a, w_b;
        logic [2:0] w_op;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            opcode = ops[$urandom_range(0, 8)];
            funct3 = f3s[$urandom_range(0, 5)];
            zero_flag = rnd_bit(); lt_flag = rnd_bit(); ltu_flag = rnd_bit();
            build_instr(opcode, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                        exp_taken(funct3, zero_flag, lt_flag, ltu_flag));
            exec_trace();
            exp_ret++;
            foreach (trace[i]) begin
                s = trace[i].st; r = trace[i].rdy; t = trace[i].taken;
                w_pc_src = (s == SJump || (s == SBranch && t)) ? PcJump :
                           (s == SJalr2) ? PcAluResult : PcIncrement;
                w_a = (s == SExecR || s == SExecI || s == SMemAdr || s == SBranch ||
                       s == SJalrC) ? SrcARd1 : (s == SLui) ? SrcAZero : SrcAOldPc;
                w_b = (s == SExecR || s == SBranch) ? SrcBRd2 :
                      (s == SJump || s == SJalr2) ? SrcBFour : SrcBImmExt;
                w_op = (s == SExecR) ? 3'b010 : (s == SExecI) ? 3'b011 :
                       (s == SBranch) ? 3'b001 : 3'b000;
                total++;
                if (obs[i].st0 !== s || obs[i].st1 !== s) begin
                    bad++; $display("FAIL rnd_state n=%0d i=%0d got=%0d/%0d want=%0d", n, i, obs[i].st0, obs[i].st1, s);
                end
                total++;
                if (obs[i].mem_req !== (s == SFetch || s == SMemWr || s == SMemRd)) begin
                    bad++; $display("FAIL rnd_mem_req n=%0d st=%0d got=%b", n, s, obs[i].mem_req);
                end
                total++;
                if (obs[i].mem_write !== (s == SMemWr)) begin
                    bad++; $display("FAIL rnd_mem_write n=%0d st=%0d got=%b", n, s, obs[i].mem_write);
                end
                total++;
                if (obs[i].adr_src !== (s == SMemWr || s == SMemRd)) begin
                    bad++; $display("FAIL rnd_adr_src n=%0d st=%0d got=%b", n, s, obs[i].adr_src);
                end
                total++;
                if (obs[i].ir_write !== (s == SFetch && r)) begin
                    bad++; $display("FAIL rnd_ir_write n=%0d st=%0d got=%b", n, s, obs[i].ir_write);
                end
                total++;
                if (obs[i].pc_update !== ((s == SFetch && r) || s == SJump || s == SJalr2 ||
                                          (s == SBranch && t))) begin
                    bad++; $display("FAIL rnd_pc_update n=%0d st=%0d got=%b", n, s, obs[i].pc_update);
                end
                total++;
                if (obs[i].pc_src !== w_pc_src) begin
                    bad++; $display("FAIL rnd_pc_src n=%0d st=%0d got=%0d want=%0d", n, s, obs[i].pc_src, w_pc_src);
                end
                total++;
                if (obs[i].reg_write !== (s == SAluWb || s == SMemWb)) begin
                    bad++; $display("FAIL rnd_reg_write n=%0d st=%0d got=%b", n, s, obs[i].reg_write);
                end
                total++;
                if (obs[i].res !== ((s == SMemWb) ? ResData : ResAluOut)) begin
                    bad++; $display("FAIL rnd_result_src n=%0d st=%0d got=%0d", n, s, obs[i].res);
                end
                total++;
                if (obs[i].branch !== (s == SBranch) || obs[i].illegal !== 1'b0) begin
                    bad++; $display("FAIL rnd_branch n=%0d st=%0d got=%b/%b", n, s, obs[i].branch, obs[i].illegal);
                end
                total++;
                if (obs[i].src_a !== w_a || obs[i].src_b !== w_b || obs[i].alu_op !== w_op) begin
                    bad++; $display("FAIL rnd_alu n=%0d st=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                                    n, s, obs[i].src_a, obs[i].src_b, obs[i].alu_op, w_a, w_b, w_op);
                end
            end
            total++;
            if (instret0 !== want_instret0() || instret1 !== want_instret1()) begin
                bad++; $display("FAIL rnd_instret n=%0d got=%0d/%0d want=%0d/%0d",
                                n, instret0, instret1, want_instret0(), want_instret1());
            end
        end
        total++; if (st0 !== SFetch) begin bad++; $display("FAIL rnd_end got=%0d want=0", st0); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addi();
        test_fetch_wait();
        test_branch();
        test_load_wait();
        test_trap();
        test_instret_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_fsm_mc.md
# control_fsm_mc

Parametrised multicycle control unit for the RV32I core, replacing the fixed-latency controller. It sequences fetch, decode, execute, memory and writeback and drives every datapath mux select and write strobe. It adds a memory request/ready handshake with unbounded wait states, full funct3 branch resolution, an illegal-instruction trap state and an optional retired-instruction counter. It sits between the instruction register and decoder on one side and the ALU, register file, PC register and unified memory port on the other.

## Interface
- `INSTRET_W`, default 32: width of the retired-instruction counter (≥ 1).
- `TRAP_STICKY`, default 1: 1 = TRAP holds until reset; 0 = TRAP is a single-cycle skip back to FETCH.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `opcode` in opcode_t: opcode field of the instruction register.
- `funct3` in 3: funct3 field of the instruction register.
- `zero_flag`, `lt_flag`, `ltu_flag` in 1 each: ALU compare results (rs1 == rs2, signed <, unsigned <).
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: store strobe; qualified by `mem_req`.
- `adr_src` out adr_src_t; `ir_write`, `reg_write`, `pc_update` out 1 each; `pc_src` out pc_src_t.
- `alu_src_a` out alu_src_a_t; `alu_src_b` out alu_src_b_t; `alu_op` out 3 (000 add, 001 branch compare, 010 R-type, 011 I-type).
- `result_src` out result_src_t; `branch` out 1: conditional-branch cycle.
- `fsm_state` out 5: current state code. `illegal_instr` out 1: high while in TRAP.
- `instret` out INSTRET_W: retired-instruction count.

## Operation
- Moore outputs, with one exception: the handshake-qualified strobes also depend on `mem_ready` and branch flags. Every output has a default every cycle. Defaults: strobes 0, `adr_src`=PC, `pc_src`=INCREMENT, `alu_src_a`=OLD_PC, `alu_src_b`=IMM_EXT, `alu_op`=000, `result_src`=ALU_OUT. No latches.
- State codes: FETCH 0, DECODE 1, EXECUTER 2, UNCONDJUMP 3, EXECUTEI 4, MEMADR 5, ALUWB 6, MEMWRITE 7, MEMREAD 8, MEMWB 9, BRANCH 10, LUI 11, AUIPC 12, JALR_CALC 13, JALR_STEP2 14, TRAP 15.
- FETCH: `mem_req`=1, `adr_src`=PC. Holds while `mem_ready`=0. On `mem_ready`=1: `ir_write`=1 and `pc_update`=1 for that cycle only; next state is DECODE.
- DECODE: ALU computes OLD_PC+IMM. Dispatch by opcode:
  - JType → UNCONDJUMP
  - RType → EXECUTER
  - IType_logic → EXECUTEI
  - IType_load / SType → MEMADR
  - BType → BRANCH
  - UType_auipc → AUIPC
  - UType_lui → LUI
  - IType_jalr → JALR_CALC
  - any other opcode → TRAP
- EXECUTER: RD1 op RD2, `alu_op`=010.
- EXECUTEI: RD1 op IMM, `alu_op`=011.
- LUI: ZERO+IMM. AUIPC: OLD_PC+IMM.
- EXECUTER, EXECUTEI, LUI and AUIPC all go to ALUWB.
- UNCONDJUMP: OLD_PC+4, `pc_update`=1, `pc_src`=JUMP; next ALUWB.
- JALR_CALC: RD1+IMM; next JALR_STEP2.
- JALR_STEP2: OLD_PC+4, `pc_src`=ALU_RESULT, `pc_update`=1; next ALUWB.
- MEMADR: RD1+IMM; next MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: `mem_req`=1, `adr_src`=RESULT. Holds until `mem_ready`, then MEMWB.
- MEMWB: `result_src`=DATA, `reg_write`=1; next FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=RESULT. Holds until `mem_ready`, then FETCH.
- ALUWB: `reg_write`=1; next FETCH.
- BRANCH: RD1 vs RD2, `alu_op`=001, `branch`=1. Taken condition by funct3:
  - 000: zero
  - 001: !zero
  - 100: lt
  - 101: !lt
  - 110: ltu
  - 111: !ltu
  - Taken → `pc_src`=JUMP, `pc_update`=1. Next FETCH.
  - funct3 010/011 → TRAP instead, with no PC update.
- TRAP: `illegal_instr`=1, all strobes 0. If TRAP_STICKY=1, stays in TRAP until reset; otherwise next state is FETCH.

## Timing
- Reset: state becomes FETCH at the first `clk` edge with `reset`=1. All registered state clears; `instret`=0.
- Outputs are decoded from state, so `mem_req`=1 in the first cycle after reset. A request in progress when reset hits is abandoned: `mem_write` drops at that edge.
- Minimum latencies, fetch included, with `mem_ready` tied high:
  - R/I/U types: 4 cycles
  - JAL: 4 cycles
  - JALR: 5 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `mem_ready` is ignored when `mem_req`=0. `mem_req` and `adr_src` stay stable throughout a wait.
- `ir_write` and `pc_update` are asserted in FETCH in exactly one cycle per instruction.

## Configuration
- `CONTROL_FSM_INSTRET_EN` defined:
  - `instret` is an INSTRET_W-bit counter that increments by 1 on the edge leaving ALUWB, MEMWB or BRANCH (non-trap), and on the completing edge of MEMWRITE.
  - It wraps from all-ones to 0 and is never incremented on entry to TRAP.
- Undefined: `instret` is tied to 0 and no counter flops exist.

## Test plan
- Reset, then `mem_ready`=1 with an addi-type opcode → `fsm_state` sequence 0,1,4,6,0. `reg_write` high only in state 6; `instret`=1 (macro on).
- FETCH with `mem_ready` low for 3 cycles → FETCH held 4 cycles, `mem_req`=1 throughout, `ir_write` one pulse on the 4th.
- BType, funct3=101: `lt_flag`=1 → no `pc_update` in BRANCH; `lt_flag`=0 → `pc_update`=1 with `pc_src`=JUMP. funct3=010 → TRAP.
- Load with `mem_ready` low 2 cycles in MEMREAD → states 0,1,5,8,8,8,9,0. `result_src`=DATA in state 9.
- Undefined opcode 7'h7F, TRAP_STICKY=1 → TRAP held 10 cycles with `illegal_instr`=1. Asserting `reset` → FETCH next cycle.
- INSTRET_W=2, 5 ALU instructions → `instret` reads 1,2,3,0,1.
